// File: rtl/window_cmd_uart_tx.sv
// Serialises a display window (x_start, y_start, x_end, y_end) as an 8-byte
// big-endian command packet over a UART 8N1 line for the display controller.
module window_cmd_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [15:0] x_start,
    input  logic [15:0] y_start,
    input  logic [15:0] x_end,
    input  logic [15:0] y_end,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        uart_txd
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [2:0]       byte_idx_reg, byte_idx_next;
    logic [63:0]      shadow_reg, shadow_next;
    logic             txd_reg, txd_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic [7:0]       byte_arr [8];
    logic [7:0]       cur_byte;
    logic [2:0]       bit_idx_inc;
    logic             baud_tick;
    logic             window_ok;

    // Byte 0 is the most significant byte of x_start, byte 7 the LSB of y_end.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_sel
            assign byte_arr[gi] = shadow_reg[63 - 8*gi -: 8];
        end
    endgenerate

    assign cur_byte    = byte_arr[byte_idx_reg];
    assign bit_idx_inc = bit_idx_reg + 3'd1;
    assign baud_tick   = (baud_cnt_reg == CNT_LAST);
    assign window_ok   = (x_start <= x_end) && (y_start <= y_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            shadow_reg   <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            shadow_reg   <= shadow_next;
            txd_reg      <= txd_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (send && window_ok) state_next = START;
            START: if (baud_tick) state_next = DATA;
            DATA:  if (baud_tick && bit_idx_reg == 3'd7) state_next = STOP;
            STOP:  if (baud_tick) state_next = (byte_idx_reg == 3'd7) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Line level and bookkeeping are computed one cycle ahead so every output is a flop.
    always_comb begin
        baud_cnt_next = (state_reg == IDLE || baud_tick) ? '0 : baud_cnt_reg + 1'b1;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        shadow_next   = shadow_reg;
        txd_next      = txd_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
                if (send) begin
                    if (window_ok) begin
                        shadow_next   = {x_start, y_start, x_end, y_end};
                        txd_next      = 1'b0;
                        busy_next     = 1'b1;
                        bit_idx_next  = '0;
                        byte_idx_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            START: begin
                if (baud_tick) begin
                    txd_next     = cur_byte[0];
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_reg == 3'd7) begin
                        txd_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        txd_next     = cur_byte[bit_idx_inc];
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (byte_idx_reg == 3'd7) begin
                        txd_next  = 1'b1;
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        byte_idx_next = byte_idx_reg + 3'd1;
                        txd_next      = 1'b0;
                    end
                end
            end
            default: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    assign uart_txd = txd_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_window_cmd_uart_tx.sv
// Bench for window_cmd_uart_tx: stimulus pushes expected bytes into a queue,
// an independent UART decoder pops and compares every byte seen on the line.
module tb_window_cmd_uart_tx;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 5000000;
    localparam int BD       = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send;
    logic [15:0] x_start, y_start, x_end, y_end;
    logic        busy, done, err, uart_txd;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rx_bytes = 0;
    logic [7:0] exp_q [$];

    window_cmd_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst_n(rst_n), .send(send),
        .x_start(x_start), .y_start(y_start), .x_end(x_end), .y_end(y_end),
        .busy(busy), .done(done), .err(err), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    endtask

    task automatic push_pkt(input logic [15:0] xs, ys, xe, ye);
        exp_q.push_back(xs[15:8]); exp_q.push_back(xs[7:0]);
        exp_q.push_back(ys[15:8]); exp_q.push_back(ys[7:0]);
        exp_q.push_back(xe[15:8]); exp_q.push_back(xe[7:0]);
        exp_q.push_back(ye[15:8]); exp_q.push_back(ye[7:0]);
    endtask

    // Drives a one-cycle send; returns on the negedge after the sampling edge.
    task automatic send_pkt(input logic [15:0] xs, ys, xe, ye, input bit expect_ok);
        @(negedge clk);
        x_start = xs; y_start = ys; x_end = xe; y_end = ye;
        send = 1'b1;
        if (expect_ok) push_pkt(xs, ys, xe, ye);
        @(negedge clk);
        send = 1'b0;
    endtask

    // Returns on the negedge where done is high (or after the cycle budget).
    task automatic wait_done(input int t0, input string name);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_timeout"}, 0, 1);
        else check({name, "_latency"}, cyc - t0, 80 * BD);
    endtask

    // UART decoder: samples every cycle of every bit so bit width is checked too.
    task automatic decode_byte();
        logic [9:0] bits;
        int unstable = 0;
        logic first;
        logic [7:0] exp_b;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BD; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (!rst_n) begin
                    $display("monitor: byte aborted by reset");
                    return;
                end
                if (c == 0) first = uart_txd;
                else if (uart_txd !== first) unstable++;
            end
            bits[b] = first;
        end
        rx_bytes++;
        check("bit_width_stable", unstable, 0);
        check("stop_bit", int'(bits[9]), 1);
        if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(bits[8:1]), -1);
        end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", int'(bits[8:1]), int'(exp_b));
            $display("rx byte %0d: 0x%02h expected 0x%02h", rx_bytes, bits[8:1], exp_b);
        end
    endtask

    initial begin
        logic prev_txd = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev_txd === 1'b1 && uart_txd === 1'b0) decode_byte();
            prev_txd = uart_txd;
        end
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bad;
        int dones;
        rst_n = 1'b0; send = 1'b0;
        x_start = '0; y_start = '0; x_end = '0; y_end = '0;

        // Reset and idle line
        repeat (5) @(negedge clk);
        check("rst_txd", int'(uart_txd), 1);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_txd", int'(uart_txd), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        check("idle_err", int'(err), 0);
        bad = 0;
        repeat (50) begin @(negedge clk); if (uart_txd !== 1'b1 || busy !== 1'b0) bad++; end
        check("idle_quiet", bad, 0);
        $display("txn reset/idle done");

        // Single packet
        send_pkt(16'h0010, 16'h0020, 16'h00FF, 16'h01E0, 1'b1);
        t0 = cyc;
        check("pkt1_busy_rise", int'(busy), 1);
        check("pkt1_start_bit", int'(uart_txd), 0);
        wait_done(t0, "pkt1");
        check("pkt1_done_txd", int'(uart_txd), 1);
        @(negedge clk);
        check("pkt1_done_pulse", int'(done), 0);
        check("pkt1_busy_fall", int'(busy), 0);
        $display("txn single packet done");

        // Invalid window
        send_pkt(16'h0100, 16'h0000, 16'h00FF, 16'h0010, 1'b0);
        check("inv_err", int'(err), 1);
        check("inv_busy", int'(busy), 0);
        @(negedge clk);
        check("inv_err_once", int'(err), 0);
        bad = 0;
        repeat (200) begin @(negedge clk); if (uart_txd !== 1'b1 || busy !== 1'b0 || err !== 1'b0) bad++; end
        check("inv_line_idle", bad, 0);
        $display("txn invalid window done");

        // Busy-ignore and input isolation
        send_pkt(16'h1234, 16'h0005, 16'h2000, 16'h0300, 1'b1);
        t0 = cyc;
        repeat (99) @(negedge clk);
        x_start = 16'h0ABC; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("ign_no_err", int'(err), 0);
        wait_done(t0, "ign");
        dones = 0; bad = 0;
        repeat (900) begin
            @(negedge clk);
            if (done) dones++;
            if (busy !== 1'b0 || uart_txd !== 1'b1) bad++;
        end
        check("ign_single_done", dones, 0);
        check("ign_no_second_pkt", bad, 0);
        $display("txn busy-ignore done");

        // Back-to-back packets
        send_pkt(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
        t0 = cyc;
        wait_done(t0, "b2b_first");
        x_start = 16'hA5A5; y_start = 16'h0F0F; x_end = 16'hFFFF; y_end = 16'h8001;
        send = 1'b1;
        push_pkt(16'hA5A5, 16'h0F0F, 16'hFFFF, 16'h8001);
        @(negedge clk);
        send = 1'b0;
        t0 = cyc;
        check("b2b_start_next", int'(uart_txd), 0);
        check("b2b_busy", int'(busy), 1);
        wait_done(t0, "b2b_second");
        $display("txn back-to-back done");

        // Reset in the middle of byte 3
        send_pkt(16'hDEAD, 16'hBEEF, 16'hFFFF, 16'hFFFF, 1'b1);
        repeat (30 * BD + BD + 25) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_txd", int'(uart_txd), 1);
        check("mid_rst_busy", int'(busy), 0);
        dones = 0;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        rst_n = 1'b1;
        repeat (20) begin @(negedge clk); if (done || busy || !uart_txd) dones++; end
        check("mid_rst_quiet", dones, 0);
        send_pkt(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        t0 = cyc;
        wait_done(t0, "after_rst");
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("txn reset mid-packet done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/window_cmd_uart_tx.md
Name: window_cmd_uart_tx

Overview:
Host-side companion of the HDMI display window controller. It takes a display window (x_start, y_start, x_end, y_end) and sends it as the 8-byte command packet that the display controller's UART receive path collects. The block frames each byte as UART 8N1 and drives the serial line directly. It is used in the loopback/test FPGA image and in the board-to-board window-setup path.

Parameters:
CLK_FREQ, 50000000, clk frequency in Hz
BAUD, 115200, serial bit rate in bits/s
BAUD_DIV, CLK_FREQ/BAUD (integer, truncated), clocks per bit; derived, do not override

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
send  input  1  request to transmit one window packet; sampled at the clk rising edge
x_start  input  16  window left column
y_start  input  16  window top row
x_end  input  16  window right column, inclusive
y_end  input  16  window bottom row, inclusive
busy  output  1  high while a packet is in flight
done  output  1  one-cycle pulse when the last stop bit completes
err  output  1  one-cycle pulse when a send request is rejected
uart_txd  output  1  serial output, idle high

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous and active-low. During reset uart_txd=1, busy=0, done=0, err=0, and every counter and the FSM return to IDLE. Reset asserted mid-packet aborts the packet immediately: the line goes high and no partial byte resumes after reset.
- FSM states: IDLE, START, DATA, STOP.
- IDLE, send=1, valid window (x_start<=x_end and y_start<=y_end, unsigned):
  - Latch all four coordinates into a shadow register. Input changes during the packet have no effect.
  - Next cycle: busy=1, uart_txd=0, state START.
- IDLE, send=1, invalid window: no transmission. err=1 for exactly one cycle (the cycle after send). busy stays 0.
- send while busy=1 is ignored: no queueing, no err.
- Byte order: x_start[15:8], x_start[7:0], y_start[15:8], y_start[7:0], x_end[15:8], x_end[7:0], y_end[15:8], y_end[7:0].
- Bit order within a byte: start bit 0, data bits LSB first, stop bit 1.
- Bit timing: a baud counter runs 0..BAUD_DIV-1. Each bit lasts exactly BAUD_DIV clocks, so each byte lasts 10*BAUD_DIV clocks.
- State transitions:
  - START -> DATA after one bit time.
  - DATA holds for 8 bit times, with a bit index 0..7.
  - STOP lasts one bit time. Then it either goes to START of the next byte, with no inter-byte gap, or finishes if the byte index is 7.
- Completion: on the final STOP expiry, state becomes IDLE, busy=0, done=1 for one cycle, and uart_txd stays 1.
  - Total time from the busy rise to the done pulse is exactly 80*BAUD_DIV cycles.
  - send asserted in the same cycle done is high is accepted (back-to-back packets). Its start bit begins on the next cycle.
- Byte index is 3 bits and is not wrapped past 7. Baud counter width is clog2(BAUD_DIV).
- uart_txd is registered, so there are no glitches. busy, done and err are registered.

Test Plan:
- Reset/idle: hold rst_n=0 for 5 cycles, then release -> uart_txd=1, busy=0, done=0, err=0, and the line stays idle with no send.
- Single packet: CLK_FREQ=50000000, BAUD=5000000 (BAUD_DIV=10); send with x_start=0x0010, y_start=0x0020, x_end=0x00FF, y_end=0x01E0.
  - A UART monitor decodes the bytes 00 10 00 20 00 FF 01 E0.
  - Each bit is 10 cycles wide.
  - done pulses exactly 800 cycles after the busy rise.
- Invalid window: send with x_start=0x0100, x_end=0x00FF -> err pulses exactly one cycle, and uart_txd stays 1 for 200 cycles with busy=0.
- Busy-ignore and input isolation:
  - Re-pulse send and change x_start to 0x0ABC at cycle 100 of a packet -> the packet content is unchanged.
  - Only one done pulse occurs, and no second packet is sent.
- Back-to-back: assert send in the done cycle -> the second start bit begins the next cycle, and the line has no idle-high gap longer than the stop bit.
- Reset mid-packet: assert rst_n=0 during byte 3's DATA state -> uart_txd=1 immediately, busy=0, and no done pulse. After release, a new send transmits the full 8 bytes correctly.
